// File: rtl/cla_sub16_pipe.sv
// ---------------------------------------------------------------------------
// cla_sub16_pipe
// Two-stage pipelined 16-bit subtractor, diff = a - b - borrow_in (mod 2^16).
// The subtractor is built as a + ~b + ~borrow_in from 4-bit carry-lookahead
// groups. The low byte is resolved in stage 1. The high byte, the borrow and
// the flags are resolved in stage 2. Valid/ready handshakes are used on both
// sides.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous, active-high; clears all state
//   in_valid   - a/b/borrow_in hold an operand set this cycle
//   in_ready   - block accepts an operand set this cycle
//   a, b       - unsigned minuend / subtrahend (16 bit)
//   borrow_in  - incoming borrow
//   out_valid  - result outputs hold a valid result
//   out_ready  - downstream takes the result this cycle
//   diff       - a - b - borrow_in modulo 2^16 (registered)
//   borrow_out - 1 iff a < b + borrow_in (registered)
//   overflow   - two's-complement overflow of the subtraction (registered)
//   zero       - 1 iff diff == 0 (registered)
// ---------------------------------------------------------------------------
module cla_sub16_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        borrow_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] diff,
    output logic        borrow_out,
    output logic        overflow,
    output logic        zero
);

    // 4-bit carry-lookahead adder group. Returns {carry_out, sum[3:0]}.
    // All internal carries come from generate/propagate terms and group
    // carry-in, so there is no rippling within the group.
    function automatic logic [4:0] cla4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Stage 1 state: low-byte result, carry into bit 8, and the high bytes
    // of both operands. Bit 7 of each high byte is the operand sign bit,
    // which the overflow flag needs in stage 2.
    logic       s1_valid;
    logic [7:0] s1_diff_lo;
    logic       s1_carry;
    logic [7:0] s1_a_hi;
    logic [7:0] s1_b_hi;

    logic       s2_valid;

    // Stage 2 can load when it is empty or its result leaves this edge.
    // Stage 1 can load when it is empty or it moves into stage 2 this edge.
    logic s2_free;
    logic accept;

    assign s2_free  = ~s2_valid | out_ready;
    assign in_ready = ~reset & (~s1_valid | s2_free);
    assign accept   = in_valid & in_ready;

    // Low byte: subtraction as a + ~b with carry-in = ~borrow_in.
    logic [4:0] lo0;
    logic [4:0] lo1;
    assign lo0 = cla4(a[3:0], ~b[3:0], ~borrow_in);
    assign lo1 = cla4(a[7:4], ~b[7:4], lo0[4]);

    // High byte, continuing from the registered carry out of bit 7.
    logic [4:0]  hi0;
    logic [4:0]  hi1;
    logic [15:0] full_diff;
    assign hi0       = cla4(s1_a_hi[3:0], ~s1_b_hi[3:0], s1_carry);
    assign hi1       = cla4(s1_a_hi[7:4], ~s1_b_hi[7:4], hi0[4]);
    assign full_diff = {hi1[3:0], hi0[3:0], s1_diff_lo};

    // Stage 1 register. It loads only on a handshake. If nothing new
    // arrives while its content moves into stage 2, it becomes empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_diff_lo <= 8'd0;
            s1_carry   <= 1'b0;
            s1_a_hi    <= 8'd0;
            s1_b_hi    <= 8'd0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_diff_lo <= {lo1[3:0], lo0[3:0]};
            s1_carry   <= lo1[4];
            s1_a_hi    <= a[15:8];
            s1_b_hi    <= b[15:8];
        end else if (s2_free) begin
            s1_valid   <= 1'b0;
        end
    end

    // Stage 2 register, which drives the outputs. Result fields load only
    // when a real result arrives, so they keep the last value while empty
    // and stay frozen while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid   <= 1'b0;
            diff       <= 16'd0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                diff       <= full_diff;
                borrow_out <= ~hi1[4];
                overflow   <= (s1_a_hi[7] != s1_b_hi[7]) &&
                              (full_diff[15] != s1_a_hi[7]);
                zero       <= (full_diff == 16'd0);
            end
        end
    end

    assign out_valid = s2_valid;

endmodule
